// File: rtl/data_path_muxs_pkg.sv
// Shared types for the pipeline controller.
//   regbits_t    : 5-bit register index used in hazard compares
//   pipe_state_t : controller state (RUN, DRAIN, HALTED)
//   run_rule_t   : which RUN-state priority rule decided the current cycle
package data_path_muxs_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    typedef enum logic [2:0] {
        R_HALT,
        R_MEM_WAIT,
        R_REDIRECT,
        R_LOAD_USE,
        R_FETCH_MISS,
        R_NORMAL
    } run_rule_t;

    // A load in EX whose destination feeds either source operand in ID.
    // Register 0 never creates a dependency.
    function automatic logic load_use_hazard(
        input logic     ren_ex,
        input logic     wen_ex,
        input regbits_t rt_ex,
        input regbits_t rs_id,
        input regbits_t rt_id
    );
        return ren_ex && wen_ex && (rt_ex != '0) &&
               ((rt_ex == rs_id) || (rt_ex == rt_id));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts up to all-ones and holds there.
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset (clears count)
//   inc   : increment request this cycle
//   count : current value
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the five-stage pipeline.
// Inputs : CLK, nRST, cache handshakes (ihit, dhit), MEM-stage data request
//          (dmemREN_EX_MEM, dmemWEN_EX_MEM), redirect_EX_MEM, load-use operands
//          (dmemREN_ID_EX, WEN_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID), halt_EX_MEM.
// Outputs: pc_enable, enable_*/flush_* per stage register, state, and three
//          saturating event counters (stall_cycles, load_use_bubbles,
//          redirect_flushes).
module pipeline_controller
    import data_path_muxs_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN_EX_MEM,
    input  logic             dmemWEN_EX_MEM,
    input  logic             redirect_EX_MEM,
    input  logic             dmemREN_ID_EX,
    input  logic             WEN_ID_EX,
    input  regbits_t         Rt_ID_EX,
    input  regbits_t         Rs_IF_ID,
    input  regbits_t         Rt_IF_ID,
    input  logic             halt_EX_MEM,
    output logic             pc_enable,
    output logic             enable_IF_ID,
    output logic             enable_ID_EX,
    output logic             enable_EX_MEM,
    output logic             enable_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             flush_MEM_WB,
    output pipe_state_t      state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] load_use_bubbles,
    output logic [CNT_W-1:0] redirect_flushes
);

    pipe_state_t next_state;
    run_rule_t   rule;
    logic        dreq;
    logic        hazard;
    logic        inc_stall, inc_load_use, inc_redirect;

    assign dreq   = dmemREN_EX_MEM || dmemWEN_EX_MEM;
    assign hazard = load_use_hazard(dmemREN_ID_EX, WEN_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID);

    // Priority decode of the RUN-state rules; first match wins.
    always_comb begin
        rule = R_NORMAL;
        if (halt_EX_MEM && (!dreq || dhit)) rule = R_HALT;
        else if (dreq && !dhit)             rule = R_MEM_WAIT;
        else if (redirect_EX_MEM)           rule = R_REDIRECT;
        else if (hazard)                    rule = R_LOAD_USE;
        else if (!ihit)                     rule = R_FETCH_MISS;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = state;
        pc_enable     = 1'b0;
        enable_IF_ID  = 1'b0;
        enable_ID_EX  = 1'b0;
        enable_EX_MEM = 1'b0;
        enable_MEM_WB = 1'b0;
        flush_IF_ID   = 1'b0;
        flush_ID_EX   = 1'b0;
        flush_EX_MEM  = 1'b0;
        flush_MEM_WB  = 1'b0;
        unique case (state)
            RUN: begin
                unique case (rule)
                    R_HALT: begin
                        enable_MEM_WB = 1'b1;
                        flush_IF_ID   = 1'b1;
                        flush_ID_EX   = 1'b1;
                        flush_EX_MEM  = 1'b1;
                        next_state    = DRAIN;
                    end
                    R_MEM_WAIT: begin
                        flush_MEM_WB  = 1'b1;
                    end
                    R_REDIRECT: begin
                        pc_enable     = 1'b1;
                        enable_IF_ID  = 1'b1;
                        enable_ID_EX  = 1'b1;
                        enable_EX_MEM = 1'b1;
                        enable_MEM_WB = 1'b1;
                        flush_IF_ID   = 1'b1;
                        flush_ID_EX   = 1'b1;
                        flush_EX_MEM  = 1'b1;
                    end
                    R_LOAD_USE: begin
                        // ID/EX enable is moot: its flush inserts the bubble.
                        enable_ID_EX  = 1'b1;
                        enable_EX_MEM = 1'b1;
                        enable_MEM_WB = 1'b1;
                        flush_ID_EX   = 1'b1;
                    end
                    R_FETCH_MISS: begin
                        enable_ID_EX  = 1'b1;
                        enable_EX_MEM = 1'b1;
                        enable_MEM_WB = 1'b1;
                        flush_IF_ID   = 1'b1;
                    end
                    default: begin
                        pc_enable     = 1'b1;
                        enable_IF_ID  = 1'b1;
                        enable_ID_EX  = 1'b1;
                        enable_EX_MEM = 1'b1;
                        enable_MEM_WB = 1'b1;
                    end
                endcase
            end
            DRAIN: begin
                enable_MEM_WB = 1'b1;
                next_state    = HALTED;
            end
            default: next_state = HALTED;
        endcase
        // Outputs are held quiet for the whole reset assertion, not just the edge.
        if (!nRST) begin
            pc_enable     = 1'b0;
            enable_IF_ID  = 1'b0;
            enable_ID_EX  = 1'b0;
            enable_EX_MEM = 1'b0;
            enable_MEM_WB = 1'b0;
            flush_IF_ID   = 1'b0;
            flush_ID_EX   = 1'b0;
            flush_EX_MEM  = 1'b0;
            flush_MEM_WB  = 1'b0;
        end
    end

    // A stall is any non-halt RUN cycle that holds the PC.
    assign inc_stall    = (state == RUN) && (rule inside {R_MEM_WAIT, R_LOAD_USE, R_FETCH_MISS});
    assign inc_load_use = (state == RUN) && (rule == R_LOAD_USE);
    assign inc_redirect = (state == RUN) && (rule == R_REDIRECT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK(CLK), .nRST(nRST), .inc(inc_stall), .count(stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_load_use_cnt (
        .CLK(CLK), .nRST(nRST), .inc(inc_load_use), .count(load_use_bubbles)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .CLK(CLK), .nRST(nRST), .inc(inc_redirect), .count(redirect_flushes)
    );

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the five-stage MIPS pipeline. Each cycle it decides the `enable_*` and `flush_*` controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the PC write enable. Its inputs are the cache handshakes, load-use detection, control-transfer resolution and halt. It runs a small drain/halt state machine and keeps saturating performance counters for stall and flush events.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `CLK` input 1: system clock, rising edge.
- `nRST` input 1: asynchronous, active-low reset.
- `ihit` input 1: instruction fetch completed this cycle.
- `dhit` input 1: data access completed this cycle.
- `dmemREN_EX_MEM`, `dmemWEN_EX_MEM` input 1 each: the instruction in MEM accesses data memory.
- `redirect_EX_MEM` input 1: the branch or jump in MEM is taken, so the PC is being redirected.
- `dmemREN_ID_EX`, `WEN_ID_EX` input 1 each: the instruction in EX is a load that writes a register.
- `Rt_ID_EX`, `Rs_IF_ID`, `Rt_IF_ID` input 5 each (`regbits_t`): operands for hazard compare.
- `halt_EX_MEM` input 1: the halt instruction is in MEM.
- `pc_enable` output 1: PC register write enable.
- `enable_IF_ID`, `enable_ID_EX`, `enable_EX_MEM`, `enable_MEM_WB` output 1 each: stage register load enables.
- `flush_IF_ID`, `flush_ID_EX`, `flush_EX_MEM`, `flush_MEM_WB` output 1 each: load a bubble on the next edge. Flush takes priority over enable inside each register.
- `state` output 2 (`pipe_state_t`): current controller state.
- `stall_cycles`, `load_use_bubbles`, `redirect_flushes` output `CNT_W` each: saturating event counters.

## Operation
- States are RUN, DRAIN and HALTED. Reset enters RUN.
- Control outputs are combinational from state and inputs. While `nRST`=0 every enable, flush and `pc_enable` output is 0.
- In RUN, conditions are evaluated in priority order. The first match decides all outputs:
  1. Halt: `halt_EX_MEM`=1 and (no data request, or `dhit`=1).
     - `enable_MEM_WB`=1; `flush_IF_ID`, `flush_ID_EX` and `flush_EX_MEM` are 1; `pc_enable`=0.
     - Next state is DRAIN.
  2. Memory wait: (`dmemREN_EX_MEM` or `dmemWEN_EX_MEM`) and `dhit`=0.
     - All enables 0, `pc_enable`=0, `flush_MEM_WB`=1.
     - Stage contents above MEM stay frozen. A pending redirect or load-use condition therefore persists and is re-evaluated after `dhit`.
  3. Redirect: `redirect_EX_MEM`=1.
     - All enables 1 and `pc_enable`=1; `flush_IF_ID`, `flush_ID_EX` and `flush_EX_MEM` are 1.
     - The redirect wins even if `ihit`=0, because the fetched word is discarded anyway.
  4. Load-use: `dmemREN_ID_EX` & `WEN_ID_EX` & `Rt_ID_EX`≠0 & (`Rt_ID_EX`==`Rs_IF_ID` or `Rt_ID_EX`==`Rt_IF_ID`).
     - `pc_enable`=0, `enable_IF_ID`=0, `flush_ID_EX`=1.
     - `enable_EX_MEM`=1 and `enable_MEM_WB`=1.
  5. Fetch miss: `ihit`=0.
     - `pc_enable`=0, `flush_IF_ID`=1; the downstream enables stay 1.
  6. Otherwise all enables are 1, `pc_enable`=1 and there are no flushes.
- DRAIN: `enable_MEM_WB`=1; all other enables and `pc_enable` are 0. Next state is HALTED.
- HALTED: all outputs 0. The only exit is `nRST`.

Counters (each saturates at all-ones and never wraps):
- `stall_cycles` increments on every RUN cycle whose `pc_enable`=0 and which is not a halt cycle.
- `load_use_bubbles` increments on a rule-4 cycle.
- `redirect_flushes` increments on a rule-3 cycle.
- All counters are frozen in DRAIN and HALTED.

## Timing
- Decisions take effect at the next rising `CLK`; there is no added latency.
- A load-use bubble lasts exactly one cycle when `ihit`=1. The re-evaluation on the following cycle sees the load already in MEM, so no compare match remains.
- Memory wait lasts as long as `dhit`=0. On the `dhit` cycle, rule 2 no longer applies and lower rules are evaluated normally.
- Halt to HALTED takes 2 edges: RUN→DRAIN, then DRAIN→HALTED. `halt` from MEM/WB is visible one edge after entering DRAIN.
- Reset asserted mid-stall or mid-drain: state returns to RUN and counters clear to 0 immediately. Outputs are forced to 0 while reset is held.

## Structure
- `pipe_state_t` (RUN=0, DRAIN=1, HALTED=2) lives in `data_path_muxs_pkg`.
- The hazard compare and the priority decode are combinational blocks inside this module.
- Sub-module `sat_counter` (parameter `W`; ports `CLK`, `nRST`, `inc`, `count`) is instantiated three times.

## Test plan
- Cold start: release `nRST` with `ihit`=1 and no hazards → `state`=RUN, all enables 1, no flushes, counters 0.
- Load-use: `dmemREN_ID_EX`=1, `WEN_ID_EX`=1, `Rt_ID_EX`=5, `Rs_IF_ID`=5, `ihit`=1 →
  - for one cycle: `pc_enable`=0, `enable_IF_ID`=0, `flush_ID_EX`=1;
  - `load_use_bubbles`=1;
  - repeat with `Rt_ID_EX`=0 → no stall.
- Memory wait with pending redirect: `dmemWEN_EX_MEM`=1, `redirect_EX_MEM`=1, `dhit`=0 for 3 cycles, then `dhit`=1 →
  - 3 cycles with `flush_MEM_WB`=1 and everything else frozen;
  - on the `dhit` cycle, the redirect flush of IF_ID, ID_EX and EX_MEM;
  - `stall_cycles`=3 and `redirect_flushes`=1.
- Fetch miss: `ihit`=0 for 2 cycles → `pc_enable`=0 and `flush_IF_ID`=1 for 2 cycles, `stall_cycles`=2.
- Halt: `halt_EX_MEM`=1 with no data request →
  - `state` goes RUN→DRAIN→HALTED;
  - afterwards all outputs stay 0 for 10 cycles regardless of inputs.
- Saturation and reset: with `CNT_W`=4, 20 fetch-miss cycles → `stall_cycles`=15. Then pulse `nRST` low mid-DRAIN → `state`=RUN and all counters 0.
